// File: rtl/tdc_result_buffer.sv
// tdc_result_buffer: small FIFO of completed TDC measurements, read out one byte at a time.
// Rev 1.0 - initial release.
`default_nettype none

module tdc_result_buffer #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int NBYTES = DATA_W / 8,
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] meas_data_i,
  input  logic              meas_valid_i,
  input  logic              rd_next_i,
  input  logic              clr_ovf_i,
  output logic [7:0]        byte_out_o,
  output logic [IDX_W-1:0]  byte_idx_o,
  output logic              out_valid_o,
  output logic [CNT_W-1:0]  fifo_count_o,
  output logic              overflow_o
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             out_valid_q, out_valid_d;

  logic w_empty, w_full, w_pop, w_retire, w_push, w_drop;
  logic [DATA_W-1:0]           w_head;
  logic [NBYTES-1:0][7:0]      w_head_bytes;

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == FULL_CNT);
  assign w_pop    = rd_next_i && !w_empty;
  assign w_retire = w_pop && (byte_idx_q == LAST_IDX);
  // A full FIFO still accepts a word when the head retires in the same cycle.
  assign w_push   = meas_valid_i && (!w_full || w_retire);
  assign w_drop   = meas_valid_i && w_full && !w_retire;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    ovf_d      = ovf_q;

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (w_retire) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      byte_idx_d = '0;
    end else if (w_pop) begin
      byte_idx_d = byte_idx_q + IDX_W'(1);
    end

    if (w_push && !w_retire)      count_d = count_q + CNT_W'(1);
    else if (!w_push && w_retire) count_d = count_q - CNT_W'(1);

    if (w_drop)         ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  // The new head is the word being written when the read pointer lands on the write slot.
  always_comb begin
    w_head = mem_q[rd_ptr_d];
    if (w_push && (wr_ptr_q == rd_ptr_d)) w_head = meas_data_i;
  end

  assign w_head_bytes = w_head;

  always_comb begin
    out_valid_d = (count_d != '0);
    byte_out_d  = out_valid_d ? w_head_bytes[byte_idx_d] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= meas_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_idx_q  <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      byte_out_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_idx_q  <= byte_idx_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      byte_out_q  <= byte_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign byte_out_o   = byte_out_q;
  assign byte_idx_o   = byte_idx_q;
  assign out_valid_o  = out_valid_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = ovf_q;

endmodule

`default_nettype wire
